qos_ctrl_fsm_param: RTL and testbench
=====================================

Name: qos_ctrl_fsm_param

Overview:
Parametrised, next-generation QoS control FSM for the PCIe traffic-class/virtual-channel path. It loads per-FIFO high/low threshold sets (main FIFO, NUM_VC virtual-channel FIFOs, NUM_D destination FIFOs) during INIT, holds them stable while traffic runs, and reports IDLE/ACTIVE/ERROR from the FIFO empty and error flags. Additions over the fixed 5-FIFO version:
- threshold sanity checking
- sticky, clearable error capture
- a debounced ACTIVE->IDLE transition
- re-INIT from IDLE

Parameters:
NUM_FIFOS, 5, number of FIFOs monitored (width of empties/errors vectors)
MF_W, 4, main-FIFO threshold width
NUM_VC, 2, number of VC FIFOs
VC_W, 16, VC threshold width
NUM_D, 2, number of destination FIFOs
D_W, 4, destination threshold width
IDLE_CYCLES, 1, consecutive all-empty cycles in ACTIVE required before entering IDLE (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset_L  in  1  synchronous active-low reset
init  in  1  request (re)initialisation / threshold load
error_clr  in  1  leave ERROR and clear captured errors
umbrales_mf_high / umbrales_mf_low  in  MF_W  main-FIFO thresholds
umbrales_vc_high / umbrales_vc_low  in  NUM_VC*VC_W  packed, VC0 in MSBs
umbrales_d_high / umbrales_d_low  in  NUM_D*D_W  packed, D0 in MSBs
fifo_empties  in  NUM_FIFOS  per-FIFO empty flags
fifo_errors  in  NUM_FIFOS  per-FIFO overflow/underflow flags
umbral_mf_high / umbral_mf_low  out  MF_W  latched thresholds
umbral_vc_high / umbral_vc_low  out  NUM_VC*VC_W  latched, same packing as inputs
umbral_d_high / umbral_d_low  out  NUM_D*D_W  latched, same packing as inputs
init_out, idle_out, active_out, error_out  out  1  one-hot state flags
cfg_error  out  1  threshold low>high detected at INIT exit
error_full  out  NUM_FIFOS  sticky captured FIFO errors

Behaviour:
- States: RESET, INIT, IDLE, ACTIVE, ERROR. State register updates on posedge clk.
- Reset (reset_L==0 at posedge):
  - state<=RESET.
  - All threshold outputs, error_full, cfg_error and the idle counter go to 0.
  - Reset overrides every other input.
- Flags are Moore-decoded from the state register and valid in the same cycle the state is held. All flags are 0 in RESET.
- RESET: with reset_L==1, next state is INIT unconditionally.
- INIT:
  - Every cycle, all threshold outputs load from their inputs.
  - Stay while init==1.
  - When init==0, priority order:
    1. Any field with low>high (unsigned, per channel) -> ERROR, cfg_error<=1.
    2. fifo_errors!=0 -> ERROR, error_full<=fifo_errors.
    3. All fifo_empties set -> IDLE.
    4. Otherwise -> ACTIVE.
- Threshold outputs are frozen outside INIT. Input changes in IDLE, ACTIVE or ERROR have no effect.
- ACTIVE, priority order:
  1. init==1 -> INIT.
  2. fifo_errors!=0 -> ERROR, error_full<=fifo_errors.
  3. Idle counter:
     - Increments each cycle all FIFOs are empty and clears on any non-empty cycle.
     - When the counter reaches IDLE_CYCLES-1 in an all-empty cycle -> IDLE, counter cleared.
     - With IDLE_CYCLES=1 this is an immediate transition.
- IDLE, priority order:
  1. init==1 -> INIT.
  2. fifo_errors!=0 -> ERROR with capture.
  3. Any FIFO non-empty -> ACTIVE, counter=0.
- ERROR:
  - error_full <= error_full | fifo_errors every cycle.
  - error_clr==1 -> INIT, with error_full and cfg_error cleared on that edge.
  - init is ignored in ERROR.
  - Otherwise stay in ERROR.
- Simultaneous events:
  - Errors beat emptiness.
  - init beats errors in ACTIVE/IDLE.
  - reset beats all.
- Reset mid-operation: the next state is RESET regardless of state. Thresholds are zeroed.
- Idle counter width: clog2(IDLE_CYCLES)+1 bits, no wrap possible.

Test Plan:
- Reset then init=1 for 2 cycles with mf 9/3, vc 0x0100/0x0040 (both), d 0xC/0x2, empties=5'b11111, then init=0 -> RESET, INIT×2, IDLE. Outputs hold these values after inputs change to 0.
- In IDLE, empties=5'b11011 -> ACTIVE next cycle. With IDLE_CYCLES=3, empties=11111 for 2 cycles then 11110 -> remains ACTIVE. Then 3 empty cycles -> IDLE after the third.
- In ACTIVE, errors=5'b00100 one cycle then 5'b10000 -> ERROR with error_full=00100, then 10100. error_clr=1 -> INIT with error_full=0.
- INIT with mf_low=5 > mf_high=4, init falls -> ERROR, cfg_error=1, error_full=0.
- Same cycle in ACTIVE: init=1 and errors=00001 -> INIT. In ERROR, init=1 without error_clr -> stays ERROR.
- reset_L=0 for one cycle while in ACTIVE -> RESET, all outputs 0, then INIT.

Source files
------------

// File: rtl/qos_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : qos_ctrl_fsm_param
// Description : QoS control FSM for the TC/VC path. Latches per-FIFO
//               thresholds in INIT and reports IDLE/ACTIVE/ERROR status.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module qos_ctrl_fsm_param #(
    parameter int NUM_FIFOS   = 5,
    parameter int MF_W        = 4,
    parameter int NUM_VC      = 2,
    parameter int VC_W        = 16,
    parameter int NUM_D       = 2,
    parameter int D_W         = 4,
    parameter int IDLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic                    error_clr,
    input  logic [MF_W-1:0]         umbrales_mf_high,
    input  logic [MF_W-1:0]         umbrales_mf_low,
    input  logic [NUM_VC*VC_W-1:0]  umbrales_vc_high,
    input  logic [NUM_VC*VC_W-1:0]  umbrales_vc_low,
    input  logic [NUM_D*D_W-1:0]    umbrales_d_high,
    input  logic [NUM_D*D_W-1:0]    umbrales_d_low,
    input  logic [NUM_FIFOS-1:0]    fifo_empties,
    input  logic [NUM_FIFOS-1:0]    fifo_errors,
    output logic [MF_W-1:0]         umbral_mf_high,
    output logic [MF_W-1:0]         umbral_mf_low,
    output logic [NUM_VC*VC_W-1:0]  umbral_vc_high,
    output logic [NUM_VC*VC_W-1:0]  umbral_vc_low,
    output logic [NUM_D*D_W-1:0]    umbral_d_high,
    output logic [NUM_D*D_W-1:0]    umbral_d_low,
    output logic                    init_out,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out,
    output logic                    cfg_error,
    output logic [NUM_FIFOS-1:0]    error_full
);

    localparam int CNT_W = $clog2(IDLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_FIFOS-1:0]   r_error_full;
    logic [NUM_FIFOS-1:0]   w_error_full_nxt;
    logic                   r_cfg_error;
    logic                   w_cfg_error_nxt;
    logic                   w_load;

    logic [MF_W-1:0]        r_mf_high;
    logic [MF_W-1:0]        r_mf_low;
    logic [NUM_VC*VC_W-1:0] r_vc_high;
    logic [NUM_VC*VC_W-1:0] r_vc_low;
    logic [NUM_D*D_W-1:0]   r_d_high;
    logic [NUM_D*D_W-1:0]   r_d_low;

    logic [NUM_VC-1:0]      w_vc_bad;
    logic [NUM_D-1:0]       w_d_bad;
    logic                   w_cfg_bad;
    logic                   w_all_empty;
    logic                   w_any_err;

    // Sanity check runs on the live inputs, which are what INIT latches on its exit edge
    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc_chk
        assign w_vc_bad[i] = umbrales_vc_low[i*VC_W +: VC_W] > umbrales_vc_high[i*VC_W +: VC_W];
    end

    for (genvar i = 0; i < NUM_D; i++) begin : g_d_chk
        assign w_d_bad[i] = umbrales_d_low[i*D_W +: D_W] > umbrales_d_high[i*D_W +: D_W];
    end

    assign w_cfg_bad   = (umbrales_mf_low > umbrales_mf_high) | (|w_vc_bad) | (|w_d_bad);
    assign w_all_empty = &fifo_empties;
    assign w_any_err   = |fifo_errors;

    always_comb begin
        w_state_nxt      = r_state;
        w_error_full_nxt = r_error_full;
        w_cfg_error_nxt  = r_cfg_error;
        w_cnt_nxt        = '0;
        w_load           = 1'b0;
        case (r_state)
            ST_RESET: w_state_nxt = ST_INIT;
            ST_INIT: begin
                w_load = 1'b1;
                if (!init) begin
                    if (w_cfg_bad) begin
                        w_state_nxt     = ST_ERROR;
                        w_cfg_error_nxt = 1'b1;
                    end else if (w_any_err) begin
                        w_state_nxt      = ST_ERROR;
                        w_error_full_nxt = fifo_errors;
                    end else if (w_all_empty) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    w_state_nxt = ST_INIT;
                end else if (w_any_err) begin
                    w_state_nxt      = ST_ERROR;
                    w_error_full_nxt = fifo_errors;
                end else if (w_all_empty) begin
                    // Debounce: only drop to IDLE after IDLE_CYCLES empty cycles in a row
                    if (r_cnt == c_idle_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (init) begin
                    w_state_nxt = ST_INIT;
                end else if (w_any_err) begin
                    w_state_nxt      = ST_ERROR;
                    w_error_full_nxt = fifo_errors;
                end else if (!w_all_empty) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                if (error_clr) begin
                    w_state_nxt      = ST_INIT;
                    w_error_full_nxt = '0;
                    w_cfg_error_nxt  = 1'b0;
                end else begin
                    w_error_full_nxt = r_error_full | fifo_errors;
                end
            end
            default: w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state      <= ST_RESET;
            r_cnt        <= '0;
            r_error_full <= '0;
            r_cfg_error  <= 1'b0;
            r_mf_high    <= '0;
            r_mf_low     <= '0;
            r_vc_high    <= '0;
            r_vc_low     <= '0;
            r_d_high     <= '0;
            r_d_low      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_error_full <= w_error_full_nxt;
            r_cfg_error  <= w_cfg_error_nxt;
            if (w_load) begin
                r_mf_high <= umbrales_mf_high;
                r_mf_low  <= umbrales_mf_low;
                r_vc_high <= umbrales_vc_high;
                r_vc_low  <= umbrales_vc_low;
                r_d_high  <= umbrales_d_high;
                r_d_low   <= umbrales_d_low;
            end
        end
    end

    assign umbral_mf_high = r_mf_high;
    assign umbral_mf_low  = r_mf_low;
    assign umbral_vc_high = r_vc_high;
    assign umbral_vc_low  = r_vc_low;
    assign umbral_d_high  = r_d_high;
    assign umbral_d_low   = r_d_low;
    assign error_full     = r_error_full;
    assign cfg_error      = r_cfg_error;

    assign init_out   = (r_state == ST_INIT);
    assign idle_out   = (r_state == ST_IDLE);
    assign active_out = (r_state == ST_ACTIVE);
    assign error_out  = (r_state == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_qos_ctrl_fsm_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_qos_ctrl_fsm_param
// Description : Directed self-checking bench for qos_ctrl_fsm_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qos_ctrl_fsm_param;

    localparam int NUM_FIFOS   = 5;
    localparam int MF_W        = 4;
    localparam int NUM_VC      = 2;
    localparam int VC_W        = 16;
    localparam int NUM_D       = 2;
    localparam int D_W         = 4;
    localparam int IDLE_CYCLES = 3;

    // Flag encoding {init, idle, active, error}
    localparam logic [3:0] c_f_none   = 4'b0000;
    localparam logic [3:0] c_f_init   = 4'b1000;
    localparam logic [3:0] c_f_idle   = 4'b0100;
    localparam logic [3:0] c_f_active = 4'b0010;
    localparam logic [3:0] c_f_error  = 4'b0001;

    logic                   clk;
    logic                   reset_L;
    logic                   init;
    logic                   error_clr;
    logic [MF_W-1:0]        umbrales_mf_high, umbrales_mf_low;
    logic [NUM_VC*VC_W-1:0] umbrales_vc_high, umbrales_vc_low;
    logic [NUM_D*D_W-1:0]   umbrales_d_high, umbrales_d_low;
    logic [NUM_FIFOS-1:0]   fifo_empties, fifo_errors;
    logic [MF_W-1:0]        umbral_mf_high, umbral_mf_low;
    logic [NUM_VC*VC_W-1:0] umbral_vc_high, umbral_vc_low;
    logic [NUM_D*D_W-1:0]   umbral_d_high, umbral_d_low;
    logic                   init_out, idle_out, active_out, error_out;
    logic                   cfg_error;
    logic [NUM_FIFOS-1:0]   error_full;

    int n_checks = 0;
    int n_fails  = 0;

    qos_ctrl_fsm_param #(
        .NUM_FIFOS(NUM_FIFOS), .MF_W(MF_W), .NUM_VC(NUM_VC), .VC_W(VC_W),
        .NUM_D(NUM_D), .D_W(D_W), .IDLE_CYCLES(IDLE_CYCLES)
    ) u_dut (
        .clk(clk), .reset_L(reset_L), .init(init), .error_clr(error_clr),
        .umbrales_mf_high(umbrales_mf_high), .umbrales_mf_low(umbrales_mf_low),
        .umbrales_vc_high(umbrales_vc_high), .umbrales_vc_low(umbrales_vc_low),
        .umbrales_d_high(umbrales_d_high), .umbrales_d_low(umbrales_d_low),
        .fifo_empties(fifo_empties), .fifo_errors(fifo_errors),
        .umbral_mf_high(umbral_mf_high), .umbral_mf_low(umbral_mf_low),
        .umbral_vc_high(umbral_vc_high), .umbral_vc_low(umbral_vc_low),
        .umbral_d_high(umbral_d_high), .umbral_d_low(umbral_d_low),
        .init_out(init_out), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .cfg_error(cfg_error), .error_full(error_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {init_out, idle_out, active_out, error_out};
    endfunction

    initial begin
        reset_L = 1'b0; init = 1'b0; error_clr = 1'b0;
        umbrales_mf_high = '0; umbrales_mf_low = '0;
        umbrales_vc_high = '0; umbrales_vc_low = '0;
        umbrales_d_high  = '0; umbrales_d_low  = '0;
        fifo_empties = '1; fifo_errors = '0;

        step(); step();
        check("rst_flags", flags(), c_f_none);
        check("rst_mf_high", umbral_mf_high, 0);
        check("rst_vc_high", umbral_vc_high, 0);
        check("rst_err_full", error_full, 0);
        check("rst_cfg_err", cfg_error, 0);

        // Threshold load
        reset_L = 1'b1; init = 1'b1;
        umbrales_mf_high = 4'd9;        umbrales_mf_low = 4'd3;
        umbrales_vc_high = 32'h01000100; umbrales_vc_low = 32'h00400040;
        umbrales_d_high  = 8'hCC;        umbrales_d_low  = 8'h22;
        fifo_empties = 5'b11111;
        step();
        check("init1_flags", flags(), c_f_init);
        check("init1_mf_high_not_loaded", umbral_mf_high, 0);
        step();
        check("init2_flags", flags(), c_f_init);
        check("init2_mf_high", umbral_mf_high, 9);
        init = 1'b0;
        step();
        check("to_idle_flags", flags(), c_f_idle);
        umbrales_mf_high = '0; umbrales_mf_low = '0;
        umbrales_vc_high = '0; umbrales_vc_low = '0;
        umbrales_d_high  = '0; umbrales_d_low  = '0;
        step();
        check("hold_flags", flags(), c_f_idle);
        check("hold_mf_high", umbral_mf_high, 9);
        check("hold_mf_low", umbral_mf_low, 3);
        check("hold_vc_high", umbral_vc_high, 64'h01000100);
        check("hold_vc_low", umbral_vc_low, 64'h00400040);
        check("hold_d_high", umbral_d_high, 8'hCC);
        check("hold_d_low", umbral_d_low, 8'h22);

        // IDLE -> ACTIVE and debounce with IDLE_CYCLES=3
        fifo_empties = 5'b11011;
        step();
        check("idle_to_active", flags(), c_f_active);
        fifo_empties = 5'b11111;
        step();
        check("deb_empty1", flags(), c_f_active);
        step();
        check("deb_empty2", flags(), c_f_active);
        fifo_empties = 5'b11110;
        step();
        check("deb_break", flags(), c_f_active);
        fifo_empties = 5'b11111;
        step();
        check("deb_run1", flags(), c_f_active);
        step();
        check("deb_run2", flags(), c_f_active);
        step();
        check("deb_run3_idle", flags(), c_f_idle);

        // Sticky error capture and clear
        fifo_empties = 5'b11011;
        step();
        check("reactive", flags(), c_f_active);
        fifo_errors = 5'b00100;
        step();
        check("err_enter", flags(), c_f_error);
        check("err_cap1", error_full, 5'b00100);
        fifo_errors = 5'b10000;
        step();
        check("err_sticky_flags", flags(), c_f_error);
        check("err_cap2", error_full, 5'b10100);
        fifo_errors = '0; error_clr = 1'b1;
        step();
        check("err_clr_flags", flags(), c_f_init);
        check("err_clr_full", error_full, 0);
        error_clr = 1'b0;

        // Config sanity: mf low > high while leaving INIT
        umbrales_mf_high = 4'd4; umbrales_mf_low = 4'd5;
        step();
        check("cfg_flags", flags(), c_f_error);
        check("cfg_err", cfg_error, 1);
        check("cfg_err_full", error_full, 0);
        check("cfg_mf_low", umbral_mf_low, 5);
        init = 1'b1;
        step();
        check("err_ignores_init", flags(), c_f_error);
        init = 1'b0; error_clr = 1'b1;
        step();
        check("cfg_clr_flags", flags(), c_f_init);
        check("cfg_clr", cfg_error, 0);
        error_clr = 1'b0; umbrales_mf_low = 4'd1;
        step();
        check("init_to_active", flags(), c_f_active);

        // init beats errors in ACTIVE
        init = 1'b1; fifo_errors = 5'b00001;
        step();
        check("init_beats_err", flags(), c_f_init);
        check("init_beats_err_full", error_full, 0);
        init = 1'b0; fifo_errors = '0;
        step();
        check("back_active", flags(), c_f_active);

        // Reset mid-operation
        reset_L = 1'b0;
        step();
        check("midrst_flags", flags(), c_f_none);
        check("midrst_mf_high", umbral_mf_high, 0);
        check("midrst_d_high", umbral_d_high, 0);
        check("midrst_vc_low", umbral_vc_low, 0);
        reset_L = 1'b1;
        step();
        check("post_rst_init", flags(), c_f_init);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
